// File: rtl/enc_16x4_seq_if.sv
// Handshake bundle for enc_16x4_seq: a vector-capture side and a beat-emit side.
interface enc_16x4_seq_if;
   logic        in_valid;
   logic [15:0] in_vec;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_code;
   logic        out_last;
   logic        out_zero;
   logic [4:0]  out_count;

   // Upstream/downstream side: presents vectors and consumes beats.
   modport master (
      output in_valid, in_vec, out_ready,
      input  in_ready, out_valid, out_code, out_last, out_zero, out_count
   );

   // Encoder side.
   modport slave (
      input  in_valid, in_vec, out_ready,
      output in_ready, out_valid, out_code, out_last, out_zero, out_count
   );
endinterface

// File: rtl/enc_16x4_seq.sv
// Sequential 16-to-4 encoder: captures a multi-hot vector and emits one beat
// per set bit (index order chosen by LSB_FIRST), each beat carrying the index,
// a last flag, a zero flag and the population count of the captured vector.
module enc_16x4_seq #(
   parameter bit LSB_FIRST = 1'b1
) (
   input logic           clk,
   input logic           rst,
   enc_16x4_seq_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t      state_reg, state_next;
   logic [15:0] pending_reg, pending_next;
   logic [3:0]  code_reg, code_next;
   logic        last_reg, last_next;
   logic        zero_reg, zero_next;
   logic [4:0]  count_reg, count_next;
   logic [15:0] remain;
   logic [4:0]  in_pop;
   logic [4:0]  remain_pop;

   // Index of the next bit to emit; an empty vector yields index 0.
   function automatic logic [3:0] pick(input logic [15:0] v);
      logic [3:0] r;
      r = 4'd0;
      if (LSB_FIRST) begin
         for (int i = 15; i >= 0; i--)
            if (v[i]) r = 4'(i);
      end else begin
         for (int i = 0; i < 16; i++)
            if (v[i]) r = 4'(i);
      end
      return r;
   endfunction

   function automatic logic [4:0] popcnt(input logic [15:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 16; i++)
         n = n + {4'd0, v[i]};
      return n;
   endfunction

   assign remain     = pending_reg & ~(16'd1 << code_reg);
   assign in_pop     = popcnt(bus.in_vec);
   assign remain_pop = popcnt(remain);

   // State and beat registers; reset discards any beats still pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         pending_reg <= 16'd0;
         code_reg    <= 4'd0;
         last_reg    <= 1'b0;
         zero_reg    <= 1'b0;
         count_reg   <= 5'd0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         code_reg    <= code_next;
         last_reg    <= last_next;
         zero_reg    <= zero_next;
         count_reg   <= count_next;
      end
   end

   // Next state: capture in IDLE, advance one beat per accepted handshake in EMIT.
   always_comb begin
      state_next   = state_reg;
      pending_next = pending_reg;
      code_next    = code_reg;
      last_next    = last_reg;
      zero_next    = zero_reg;
      count_next   = count_reg;
      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               pending_next = bus.in_vec;
               code_next    = pick(bus.in_vec);
               count_next   = in_pop;
               zero_next    = (bus.in_vec == 16'd0);
               last_next    = (in_pop <= 5'd1);
               state_next   = EMIT;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               if (last_reg) begin
                  state_next   = IDLE;
                  pending_next = 16'd0;
                  code_next    = 4'd0;
                  last_next    = 1'b0;
                  zero_next    = 1'b0;
                  count_next   = 5'd0;
               end else begin
                  pending_next = remain;
                  code_next    = pick(remain);
                  last_next    = (remain_pop == 5'd1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == EMIT);
   assign bus.out_code  = code_reg;
   assign bus.out_last  = last_reg;
   assign bus.out_zero  = zero_reg;
   assign bus.out_count = count_reg;

endmodule
